// File: rtl/tx_lane_scheduler_if.sv
// Handshake and data bundle between the VC queues / PHY TX path and the lane scheduler.
// The scheduler attaches through the slave modport; whoever feeds the queues uses master.
interface tx_lane_scheduler_if;
   logic        enable;
   logic        pause;
   logic [3:0]  vc_valid;
   logic [31:0] vc_data0;
   logic [31:0] vc_data1;
   logic [31:0] vc_data2;
   logic [31:0] vc_data3;
   logic [3:0]  vc_pop;
   logic [31:0] data_out;
   logic        valid_out;
   logic [1:0]  state;
   logic [1:0]  active_vc;
   logic        sync_done;

   modport master (
      output enable, pause, vc_valid, vc_data0, vc_data1, vc_data2, vc_data3,
      input  vc_pop, data_out, valid_out, state, active_vc, sync_done
   );

   modport slave (
      input  enable, pause, vc_valid, vc_data0, vc_data1, vc_data2, vc_data3,
      output vc_pop, data_out, valid_out, state, active_vc, sync_done
   );
endinterface

// File: rtl/tx_lane_scheduler.sv
// Link bring-up (sync burst) followed by round-robin, burst-capped sharing of the PHY
// 32-bit input between four show-ahead VC queues, with same-cycle backpressure.
module tx_lane_scheduler #(
   parameter int          SYNC_COUNT = 4,
   parameter int          MAX_BURST  = 4,
   parameter logic [31:0] COM_WORD   = 32'hBCBCBCBC,
   parameter logic [31:0] IDLE_WORD  = 32'h7C7C7C7C
) (
   input logic              clk,
   input logic              reset,
   tx_lane_scheduler_if.slave lane
);

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_SYNC   = 2'd1,
      ST_IDLE   = 2'd2,
      ST_ACTIVE = 2'd3
   } state_t;

   localparam logic [3:0] SyncLast = 4'(SYNC_COUNT - 1);
   localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

   state_t      r_state;
   logic [3:0]  r_syncCnt;
   logic [1:0]  r_cur;
   logic [3:0]  r_burstCnt;
   logic [31:0] r_dataOut;
   logic        r_validOut;
   logic        r_syncDone;

   state_t      w_stateNext;
   logic [3:0]  w_syncCntNext;
   logic [1:0]  w_curNext;
   logic [3:0]  w_burstCntNext;
   logic [31:0] w_dataOutNext;
   logic        w_validOutNext;
   logic        w_syncDoneNext;

   logic [31:0] w_vcData [4];
   logic        w_grant;
   logic        w_keep;
   logic [1:0]  w_sel;
   logic [1:0]  w_idx;

   assign w_vcData[0] = lane.vc_data0;
   assign w_vcData[1] = lane.vc_data1;
   assign w_vcData[2] = lane.vc_data2;
   assign w_vcData[3] = lane.vc_data3;

   // Arbiter: the loop runs from lowest to highest priority so the last hit wins;
   // offset 4 wraps to cur itself, which is therefore the lowest-priority candidate.
   always_comb begin
      w_grant = !reset && lane.enable && !lane.pause && (lane.vc_valid != 4'b0000) &&
                ((r_state == ST_IDLE) || (r_state == ST_ACTIVE));
      w_keep  = (r_state == ST_ACTIVE) && lane.vc_valid[r_cur] && (r_burstCnt < MaxBurst);
      w_sel   = r_cur;
      w_idx   = r_cur;
      if (!w_keep) begin
         for (int k = 4; k >= 1; k--) begin
            w_idx = r_cur + 2'(k);
            if (lane.vc_valid[w_idx]) begin
               w_sel = w_idx;
            end
         end
      end
   end

   assign lane.vc_pop = w_grant ? (4'b0001 << w_sel) : 4'b0000;

   always_comb begin
      w_stateNext    = r_state;
      w_syncCntNext  = r_syncCnt;
      w_curNext      = r_cur;
      w_burstCntNext = r_burstCnt;
      w_dataOutNext  = r_dataOut;
      w_validOutNext = r_validOut;
      w_syncDoneNext = r_syncDone;

      if (!lane.enable) begin
         w_stateNext    = ST_RESET;
         w_syncCntNext  = 4'd0;
         w_curNext      = 2'd3;
         w_burstCntNext = 4'd0;
         w_dataOutNext  = 32'd0;
         w_validOutNext = 1'b0;
         w_syncDoneNext = 1'b0;
      end else begin
         case (r_state)
            ST_RESET: begin
               w_dataOutNext  = 32'd0;
               w_validOutNext = 1'b0;
               w_syncDoneNext = 1'b0;
               w_stateNext    = ST_SYNC;
               w_syncCntNext  = 4'd0;
            end
            ST_SYNC: begin
               w_dataOutNext  = COM_WORD;
               w_validOutNext = 1'b1;
               w_syncCntNext  = r_syncCnt + 4'd1;
               if (r_syncCnt == SyncLast) begin
                  w_stateNext    = ST_IDLE;
                  w_syncDoneNext = 1'b1;
               end
            end
            default: begin
               if (w_grant) begin
                  w_dataOutNext  = w_vcData[w_sel];
                  w_validOutNext = 1'b1;
                  w_stateNext    = ST_ACTIVE;
                  w_curNext      = w_sel;
                  w_burstCntNext = w_keep ? (r_burstCnt + 4'd1) : 4'd1;
               end else begin
                  w_dataOutNext  = IDLE_WORD;
                  w_validOutNext = 1'b0;
                  // A paused burst keeps its slot; anything else drops back to IDLE.
                  if (!(lane.pause && (r_state == ST_ACTIVE))) begin
                     w_stateNext    = ST_IDLE;
                     w_burstCntNext = 4'd0;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_RESET;
         r_syncCnt  <= 4'd0;
         r_cur      <= 2'd3;
         r_burstCnt <= 4'd0;
         r_dataOut  <= 32'd0;
         r_validOut <= 1'b0;
         r_syncDone <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_syncCnt  <= w_syncCntNext;
         r_cur      <= w_curNext;
         r_burstCnt <= w_burstCntNext;
         r_dataOut  <= w_dataOutNext;
         r_validOut <= w_validOutNext;
         r_syncDone <= w_syncDoneNext;
      end
   end

   assign lane.data_out  = r_dataOut;
   assign lane.valid_out = r_validOut;
   assign lane.state     = r_state;
   assign lane.active_vc = r_cur;
   assign lane.sync_done = r_syncDone;

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Directed bench for tx_lane_scheduler: bring-up, single VC, fairness, backpressure,
// enable drop and an asynchronous reset pulse, all with hand-computed expectations.
module tb_tx_lane_scheduler;

   localparam logic [31:0] Com  = 32'hBCBCBCBC;
   localparam logic [31:0] Idle = 32'h7C7C7C7C;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   tx_lane_scheduler_if lane ();

   tx_lane_scheduler #(
      .SYNC_COUNT (4),
      .MAX_BURST  (4),
      .COM_WORD   (32'hBCBCBCBC),
      .IDLE_WORD  (32'h7C7C7C7C)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .lane  (lane.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] vcWord(input int vc);
      return 32'h0A0A0A00 | 32'(vc);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic en, input logic pa, input logic [3:0] vv);
      lane.enable   = en;
      lane.pause    = pa;
      lane.vc_valid = vv;
      #1;
   endtask

   // Check the combinational pop, take one edge, then check the registered word.
   task automatic checkCycle(input string tag, input logic [3:0] expPop,
                             input logic [31:0] expData, input logic expValid);
      checkOutput({tag, "_pop"}, 32'(lane.vc_pop), 32'(expPop));
      tick();
      checkOutput({tag, "_data"}, lane.data_out, expData);
      checkOutput({tag, "_valid"}, 32'(lane.valid_out), 32'(expValid));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      lane.enable   = 1'b0;
      lane.pause    = 1'b0;
      lane.vc_valid = 4'b0000;
      lane.vc_data0 = vcWord(0);
      lane.vc_data1 = vcWord(1);
      lane.vc_data2 = vcWord(2);
      lane.vc_data3 = vcWord(3);
      tick();
      tick();

      checkOutput("rst_state", 32'(lane.state), 32'd0);
      checkOutput("rst_valid", 32'(lane.valid_out), 32'd0);
      checkOutput("rst_data", lane.data_out, 32'd0);
      checkOutput("rst_sync_done", 32'(lane.sync_done), 32'd0);
      checkOutput("rst_active_vc", 32'(lane.active_vc), 32'd3);

      // Bring-up: enable seen at edge k, COM words after edges k+1..k+4.
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 4'b0000);
      tick();
      checkOutput("bu_state_sync", 32'(lane.state), 32'd1);
      checkOutput("bu_valid_k", 32'(lane.valid_out), 32'd0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("bu_sync_done_low", 32'(lane.sync_done), 32'd0);
         tick();
         checkOutput("bu_com_data", lane.data_out, Com);
         checkOutput("bu_com_valid", 32'(lane.valid_out), 32'd1);
      end
      checkOutput("bu_state_idle", 32'(lane.state), 32'd2);
      checkOutput("bu_sync_done", 32'(lane.sync_done), 32'd1);
      checkCycle("bu_idle", 4'b0000, Idle, 1'b0);

      // Fairness: all VCs valid, groups of four starting at VC0, no bubbles.
      applyStimulus(1'b1, 1'b0, 4'b1111);
      for (int i = 0; i < 20; i++) begin
         int vc;
         vc = (i / 4) % 4;
         checkCycle("fair", 4'b0001 << vc, vcWord(vc), 1'b1);
         checkOutput("fair_active_vc", 32'(lane.active_vc), 32'(vc));
      end
      applyStimulus(1'b1, 1'b0, 4'b0000);
      checkCycle("fair_drain", 4'b0000, Idle, 1'b0);
      checkOutput("fair_drain_state", 32'(lane.state), 32'd2);

      // Single requester VC2: re-granted past the burst cap, words 1..6 in order.
      for (int i = 1; i <= 6; i++) begin
         lane.vc_data2 = 32'(i);
         applyStimulus(1'b1, 1'b0, 4'b0100);
         checkCycle("single", 4'b0100, 32'(i), 1'b1);
      end
      checkOutput("single_active_vc", 32'(lane.active_vc), 32'd2);
      applyStimulus(1'b1, 1'b0, 4'b0000);
      checkCycle("single_drain", 4'b0000, Idle, 1'b0);

      // Backpressure mid-burst of VC1 (VC2 also requesting).
      lane.vc_data1 = 32'h101;
      lane.vc_data2 = 32'h201;
      applyStimulus(1'b1, 1'b0, 4'b0110);
      checkCycle("bp_w1", 4'b0010, 32'h101, 1'b1);
      lane.vc_data1 = 32'h102;
      applyStimulus(1'b1, 1'b0, 4'b0110);
      checkCycle("bp_w2", 4'b0010, 32'h102, 1'b1);
      lane.vc_data1 = 32'h103;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 4'b0110);
         checkCycle("bp_pause", 4'b0000, Idle, 1'b0);
         checkOutput("bp_pause_state", 32'(lane.state), 32'd3);
         checkOutput("bp_pause_vc", 32'(lane.active_vc), 32'd1);
      end
      applyStimulus(1'b1, 1'b0, 4'b0110);
      checkCycle("bp_w3", 4'b0010, 32'h103, 1'b1);
      lane.vc_data1 = 32'h104;
      applyStimulus(1'b1, 1'b0, 4'b0110);
      checkCycle("bp_w4", 4'b0010, 32'h104, 1'b1);
      lane.vc_data1 = 32'h105;
      applyStimulus(1'b1, 1'b0, 4'b0110);
      checkCycle("bp_rotate", 4'b0100, 32'h201, 1'b1);
      checkOutput("bp_rotate_vc", 32'(lane.active_vc), 32'd2);

      // Enable drop during ACTIVE.
      applyStimulus(1'b0, 1'b0, 4'b0110);
      checkCycle("en_drop", 4'b0000, 32'd0, 1'b0);
      checkOutput("en_drop_state", 32'(lane.state), 32'd0);
      checkOutput("en_drop_sync_done", 32'(lane.sync_done), 32'd0);
      checkOutput("en_drop_active_vc", 32'(lane.active_vc), 32'd3);

      // Re-enable repeats the sync burst.
      applyStimulus(1'b1, 1'b0, 4'b0000);
      tick();
      checkOutput("reen_state_sync", 32'(lane.state), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("reen_com_data", lane.data_out, Com);
         checkOutput("reen_com_valid", 32'(lane.valid_out), 32'd1);
      end
      checkOutput("reen_state_idle", 32'(lane.state), 32'd2);
      checkOutput("reen_sync_done", 32'(lane.sync_done), 32'd1);

      // Async reset pulse between edges, mid-burst of VC0.
      lane.vc_data0 = vcWord(0);
      lane.vc_data1 = vcWord(1);
      lane.vc_data2 = vcWord(2);
      applyStimulus(1'b1, 1'b0, 4'b1111);
      checkCycle("ar_w1", 4'b0001, vcWord(0), 1'b1);
      checkCycle("ar_w2", 4'b0001, vcWord(0), 1'b1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("ar_state", 32'(lane.state), 32'd0);
      checkOutput("ar_valid", 32'(lane.valid_out), 32'd0);
      checkOutput("ar_data", lane.data_out, 32'd0);
      checkOutput("ar_sync_done", 32'(lane.sync_done), 32'd0);
      checkOutput("ar_pop", 32'(lane.vc_pop), 32'd0);
      #1;
      reset = 1'b0;
      tick();
      checkOutput("ar_resync_state", 32'(lane.state), 32'd1);
      checkOutput("ar_sync_pop", 32'(lane.vc_pop), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
      end
      checkOutput("ar_resync_data", lane.data_out, Com);
      checkOutput("ar_resync_done", 32'(lane.sync_done), 32'd1);
      checkCycle("ar_first_grant", 4'b0001, vcWord(0), 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
